// File: rtl/irq_req_gen.sv
// Interrupt request front-end: synchronises external lines, tracks pending state and
// raises one trap request at a time. Define IRQ_EDGE_EN for edge-triggered sources.
module irq_req_gen #(
    parameter int XLEN     = 32,
    parameter int NIRQ     = 16,
    parameter int VEC_W    = 5,
    parameter int SYNC_STG = 2
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [NIRQ-1:0]  i_irq_src,
    input  logic [XLEN-1:0]  i_csr_mstatus,
    input  logic [XLEN-1:0]  i_csr_mie,
    input  logic             i_trap_ack,
    input  logic             i_mret,
    output logic             o_trap_vld,
    output logic [VEC_W-1:0] o_trapvec_id,
    output logic [XLEN-1:0]  o_csr_mip,
    output logic             o_in_svc
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_SVC  = 2'd2;

    logic [NIRQ-1:0]  sync_q [SYNC_STG];
    logic [NIRQ-1:0]  sync_d [SYNC_STG];
    logic [NIRQ-1:0]  pend_q, pend_d;
    logic [1:0]       state_q, state_d;
    logic             vld_q, vld_d;
    logic             svc_q, svc_d;
    logic [VEC_W-1:0] id_q, id_d;
    logic [3:0]       idx_q, idx_d;
    logic [NIRQ-1:0]  sync_out_s;
    logic [NIRQ-1:0]  elig_s;
    logic             any_s;
    logic [3:0]       win_s;
    logic [4:0]       vec5_s;

    // Synchroniser chain input shifting
    always_comb begin
        sync_d[0] = i_irq_src;
        for (int k = 1; k < SYNC_STG; k++) begin
            sync_d[k] = sync_q[k-1];
        end
    end

    assign sync_out_s = sync_q[SYNC_STG-1];

    // Synchroniser flops
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int k = 0; k < SYNC_STG; k++) begin
                sync_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < SYNC_STG; k++) begin
                sync_q[k] <= sync_d[k];
            end
        end
    end

`ifdef IRQ_EDGE_EN
    logic [NIRQ-1:0] s_prev_q;
    logic [NIRQ-1:0] ack_clr_s;

    // Edge mode: rising edge sets, ack clears only the acknowledged index; set wins
    always_comb begin
        ack_clr_s = '0;
        if ((state_q == ST_REQ) && i_trap_ack) begin
            ack_clr_s[idx_q] = 1'b1;
        end else begin
            ack_clr_s = '0;
        end
        pend_d = (sync_out_s & ~s_prev_q) | (pend_q & ~ack_clr_s);
    end

    // Previous synchronised sample for edge detection
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            s_prev_q <= '0;
        end else begin
            s_prev_q <= sync_out_s;
        end
    end
`else
    // Level mode: pending simply follows the synchronised line
    always_comb begin
        pend_d = sync_out_s;
    end
`endif

    // Eligibility and lowest-index-wins arbitration
    always_comb begin
        elig_s = pend_q & i_csr_mie[16 +: NIRQ];
        any_s  = |elig_s;
        win_s  = 4'd0;
        for (int i = NIRQ - 1; i >= 0; i--) begin
            if (elig_s[i]) begin
                win_s = 4'(i);
            end else begin
                win_s = win_s;
            end
        end
        vec5_s = 5'd16 + {1'b0, win_s};
    end

    // Request/service FSM; request fields are frozen while a request is outstanding
    always_comb begin
        state_d = state_q;
        vld_d   = vld_q;
        svc_d   = svc_q;
        id_d    = id_q;
        idx_d   = idx_q;
        case (state_q)
            ST_IDLE: begin
                if (i_csr_mstatus[3] && any_s) begin
                    state_d   = ST_REQ;
                    vld_d     = 1'b1;
                    idx_d     = win_s;
                    id_d      = '0;
                    id_d[4:0] = vec5_s;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (i_trap_ack) begin
                    state_d = ST_SVC;
                    vld_d   = 1'b0;
                    svc_d   = 1'b1;
                end else begin
                    state_d = ST_REQ;
                end
            end
            ST_SVC: begin
                if (i_mret) begin
                    state_d = ST_IDLE;
                    svc_d   = 1'b0;
                end else begin
                    state_d = ST_SVC;
                end
            end
            default: begin
                state_d = ST_IDLE;
                vld_d   = 1'b0;
                svc_d   = 1'b0;
            end
        endcase
    end

    // State, pending and output registers
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            pend_q  <= '0;
            state_q <= ST_IDLE;
            vld_q   <= 1'b0;
            svc_q   <= 1'b0;
            id_q    <= '0;
            idx_q   <= 4'd0;
        end else begin
            pend_q  <= pend_d;
            state_q <= state_d;
            vld_q   <= vld_d;
            svc_q   <= svc_d;
            id_q    <= id_d;
            idx_q   <= idx_d;
        end
    end

    // Pending view: flop outputs placed at bits 16.., all else zero
    always_comb begin
        o_csr_mip = '0;
        o_csr_mip[16 +: NIRQ] = pend_q;
    end

    assign o_trap_vld   = vld_q;
    assign o_in_svc     = svc_q;
    assign o_trapvec_id = id_q;

endmodule

// File: tb/tb_irq_req_gen.sv
// Randomised bench for irq_req_gen with a history-based reference model.
module tb_irq_req_gen;
    localparam int SYNC = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] src;
    logic [31:0] mstatus, mie;
    logic        ack, mret;
    logic        vld, in_svc;
    logic [4:0]  id;
    logic [31:0] mip;

    int errs = 0;
    int checks = 0;

    logic [15:0] hist[$];
    logic [15:0] m_pend;
    int          m_phase;   // 0 idle, 1 requesting, 2 in service
    int          m_idx;

    irq_req_gen #(.XLEN(32), .NIRQ(16), .VEC_W(5), .SYNC_STG(SYNC)) dut (
        .i_clk(clk), .i_rst(rst), .i_irq_src(src), .i_csr_mstatus(mstatus),
        .i_csr_mie(mie), .i_trap_ack(ack), .i_mret(mret), .o_trap_vld(vld),
        .o_trapvec_id(id), .o_csr_mip(mip), .o_in_svc(in_svc)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // value of src sampled 'back' edges before the most recent one (0 before reset history)
    function automatic logic [15:0] hist_at(input int back);
        if (hist.size() > back) return hist[hist.size() - 1 - back];
        return 16'h0000;
    endfunction

    task automatic model_edge();
        logic [15:0] elig, nxt;
        int win;
        if (rst) begin
            hist.delete();
            m_pend = 16'h0000;
            m_phase = 0;
            return;
        end
        hist.push_back(src);
        if (hist.size() > 8) void'(hist.pop_front());
        elig = m_pend & mie[31:16];
        win = -1;
        for (int i = 0; i < 16; i++) begin
            if (elig[i] && win < 0) win = i;
        end
`ifdef IRQ_EDGE_EN
        nxt = hist_at(SYNC) & ~hist_at(SYNC + 1);
        for (int i = 0; i < 16; i++) begin
            if (m_pend[i] && !(m_phase == 1 && ack && m_idx == i)) nxt[i] = 1'b1;
        end
`else
        nxt = hist_at(SYNC);
`endif
        m_pend = nxt;
        if (m_phase == 0 && mstatus[3] && win >= 0) begin
            m_phase = 1;
            m_idx = win;
        end else if (m_phase == 1 && ack) begin
            m_phase = 2;
        end else if (m_phase == 2 && mret) begin
            m_phase = 0;
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_val("vld", {31'd0, vld}, {31'd0, m_phase == 1});
        check_val("in_svc", {31'd0, in_svc}, {31'd0, m_phase == 2});
        check_val("mip", mip, {m_pend, 16'h0000});
        if (m_phase == 1) check_val("id", {27'd0, id}, 32'(16 + m_idx));
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic wait_vld();
        int n = 0;
        while (!vld && n < 12) begin
            step();
            n++;
        end
        if (!vld) check_val("vld_timeout", 32'd0, 32'd1);
    endtask

    task automatic pulse_ack();
        ack = 1'b1; step(); ack = 1'b0;
    endtask

    task automatic pulse_mret();
        mret = 1'b1; step(); mret = 1'b0;
    endtask

    initial begin
        rst = 1'b1; src = 16'h0; mstatus = 32'h0; mie = 32'h0; ack = 1'b0; mret = 1'b0;
        m_pend = 16'h0; m_phase = 0; m_idx = 0;
        steps(2);
        check_val("rst_id", {27'd0, id}, 32'd0);
        rst = 1'b0;
        step();

        // single interrupt: request exactly at the fourth edge
        mie = 32'h0001_0000; mstatus = 32'h8; src = 16'h0001;
        for (int n = 1; n <= 4; n++) begin
            step();
            check_val("lat", {31'd0, vld}, {31'd0, n == 4});
        end
        check_val("t2_id", {27'd0, id}, 32'd16);
        src = 16'h0;
        pulse_ack();
        check_val("t2_svc", {31'd0, in_svc}, 32'd1);
        steps(4);
        pulse_mret();
        check_val("t2_ret", {31'd0, in_svc}, 32'd0);
        steps(2);

        // priority: 2 beats 5, 5 follows one cycle after return to idle
        mie = (32'd1 << 18) | (32'd1 << 21);
        src = 16'h0024;
        wait_vld();
        check_val("t3_first", {27'd0, id}, 32'd18);
        src = 16'h0020;
        pulse_ack();
        steps(4);
        pulse_mret();
        check_val("t3_gap", {31'd0, vld}, 32'd0);
        step();
        check_val("t3_second", {27'd0, id}, 32'd21);
        check_val("t3_vld", {31'd0, vld}, 32'd1);
        src = 16'h0;
        pulse_ack();
        steps(4);
        pulse_mret();
        steps(2);

        // gating by MIE, then hold under withdrawal, stray ack/mret
        mstatus = 32'h0; mie = 32'h0008_0000; src = 16'h0008;
        steps(5);
        check_val("t4_mip", {31'd0, mip[19]}, 32'd1);
        check_val("t4_novld", {31'd0, vld}, 32'd0);
        mstatus = 32'h8;
        step();
        check_val("t4_vld", {31'd0, vld}, 32'd1);
        check_val("t4_id", {27'd0, id}, 32'd19);
        src = 16'h0; mie = 32'h0; mstatus = 32'h0;
        steps(5);
        pulse_mret();
        check_val("t5_hold", {27'd0, id}, 32'd19);
        check_val("t5_vld", {31'd0, vld}, 32'd1);
        pulse_ack();
        pulse_mret();
        pulse_ack();
        check_val("t5_idle", {31'd0, vld | in_svc}, 32'd0);

        // reset in the middle of a request
        mstatus = 32'h8; mie = 32'h0001_0000; src = 16'h0001;
        wait_vld();
        rst = 1'b1;
        step();
        check_val("t1_mip", mip, 32'd0);
        rst = 1'b0; src = 16'h0;
        steps(3);

        // randomised traffic
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 5) == 0) src = src ^ (16'h1 << $urandom_range(0, 15));
            if ($urandom_range(0, 40) == 0) mie = $urandom() | $urandom();
            mstatus = ($urandom_range(0, 9) != 0) ? 32'h8 : 32'h0;
            ack  = vld ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 19) == 0);
            mret = in_svc ? ($urandom_range(0, 4) == 0) : ($urandom_range(0, 19) == 0);
            rst  = ($urandom_range(0, 499) == 0);
            step();
        end
        rst = 1'b0; ack = 1'b0; mret = 1'b0;
        step();

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
